doled_rx: RTL and testbench

DOLED_RX -- requirements
Module: doled_rx

---
 rtl/doled_rx.sv | 184 ++++++++++++++++++
 tb/tb_doled_rx.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/doled_rx.sv
// doled_rx: receiver for a serial LED stream (APA102-style framing).
// mosi/sck are synchronized to doled_rx_clk. Data bits are shifted in on
// sck rising edges. 32-bit words are decoded as START, LED or END frames.
// Optional feature: define DOLED_RX_TIMEOUT_EN to make a partial frame abort
// after TIMEOUT_CYCLES clocks with no sck edge.
module doled_rx #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       doled_rx_clk,
  input  logic       doled_rx_reset,
  input  logic       mosi,
  input  logic       sck,
  output logic [7:0] blue_output,
  output logic [7:0] green_output,
  output logic [7:0] red_output,
  output logic [4:0] bright_output,
  output logic [1:0] type_output,
  output logic       frame_valid,
  output logic [7:0] led_index,
  output logic       frame_error
);

  localparam logic [1:0] TYPE_START = 2'd0;
  localparam logic [1:0] TYPE_LED   = 2'd1;
  localparam logic [1:0] TYPE_END   = 2'd2;

  typedef enum logic {RX_HUNT, RX_FRAME} state_t;

  state_t      state, state_nx;
  logic        mosi_s1, mosi_s2, sck_s1, sck_s2, sck_d;
  logic        sck_rise;
  logic [31:0] shift_q, shift_nx, word;
  logic [4:0]  bit_cnt, bit_cnt_nx;
  logic [5:0]  fill_cnt;
  logic        first_led, first_led_nx;
  logic [7:0]  blue_nx, green_nx, red_nx, idx_nx;
  logic [4:0]  bright_nx;
  logic [1:0]  type_nx;
  logic        valid_nx, error_nx;

`ifdef DOLED_RX_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] idle_cnt, idle_nx;
`endif

  // Two-flop synchronizers; sck_d holds the previous synchronized sck sample.
  always_ff @(posedge doled_rx_clk) begin
    if (doled_rx_reset) begin
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
      sck_d   <= 1'b0;
    end else begin
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
      sck_s1  <= sck;
      sck_s2  <= sck_s1;
      sck_d   <= sck_s2;
    end
  end

  assign sck_rise = sck_s2 & ~sck_d;
  assign word     = {shift_q[30:0], mosi_s2};

  // Count bits received since reset. The shift register resets to zero, so
  // a START may only be seen once 32 real bits have actually arrived.
  always_ff @(posedge doled_rx_clk) begin
    if (doled_rx_reset)
      fill_cnt <= '0;
    else if (sck_rise && fill_cnt != 6'd32)
      fill_cnt <= fill_cnt + 6'd1;
  end

  // Next-state and next-output logic: framing, word decode, idle abort.
  always_comb begin
    state_nx     = state;
    shift_nx     = shift_q;
    bit_cnt_nx   = bit_cnt;
    first_led_nx = first_led;
    blue_nx      = blue_output;
    green_nx     = green_output;
    red_nx       = red_output;
    bright_nx    = bright_output;
    type_nx      = type_output;
    idx_nx       = led_index;
    valid_nx     = 1'b0;
    error_nx     = 1'b0;
`ifdef DOLED_RX_TIMEOUT_EN
    idle_nx      = '0;
`endif
    if (sck_rise) begin
      shift_nx = word;
      if (state == RX_HUNT) begin
        if (word == 32'h0 && fill_cnt >= 6'd31) begin
          state_nx     = RX_FRAME;
          bit_cnt_nx   = 5'd0;
          idx_nx       = 8'd0;
          first_led_nx = 1'b1;
          type_nx      = TYPE_START;
          valid_nx     = 1'b1;
        end
      end else begin
        bit_cnt_nx = bit_cnt + 5'd1;
        if (bit_cnt == 5'd31) begin
          // All-ones is always END, even if it was meant as a full-level LED.
          if (word == 32'hFFFF_FFFF) begin
            state_nx = RX_HUNT;
            type_nx  = TYPE_END;
            valid_nx = 1'b1;
          end else if (word == 32'h0) begin
            idx_nx       = 8'd0;
            first_led_nx = 1'b1;
            type_nx      = TYPE_START;
            valid_nx     = 1'b1;
          end else if (word[31:29] == 3'b111) begin
            bright_nx    = word[28:24];
            blue_nx      = word[23:16];
            green_nx     = word[15:8];
            red_nx       = word[7:0];
            type_nx      = TYPE_LED;
            valid_nx     = 1'b1;
            first_led_nx = 1'b0;
            if (!first_led && led_index != 8'hFF)
              idx_nx = led_index + 8'd1;
          end else begin
            state_nx = RX_HUNT;
            error_nx = 1'b1;
          end
        end
      end
    end
`ifdef DOLED_RX_TIMEOUT_EN
    // Idle clocks only accumulate inside a partially received word.
    if (state == RX_FRAME && bit_cnt != 5'd0 && !sck_rise) begin
      if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
        state_nx   = RX_HUNT;
        bit_cnt_nx = 5'd0;
        error_nx   = 1'b1;
      end else begin
        idle_nx = idle_cnt + 1'b1;
      end
    end
`endif
  end

  // State, shift register and registered outputs.
  always_ff @(posedge doled_rx_clk) begin
    if (doled_rx_reset) begin
      state         <= RX_HUNT;
      shift_q       <= '0;
      bit_cnt       <= '0;
      first_led     <= 1'b0;
      blue_output   <= '0;
      green_output  <= '0;
      red_output    <= '0;
      bright_output <= '0;
      type_output   <= TYPE_START;
      led_index     <= '0;
      frame_valid   <= 1'b0;
      frame_error   <= 1'b0;
`ifdef DOLED_RX_TIMEOUT_EN
      idle_cnt      <= '0;
`endif
    end else begin
      state         <= state_nx;
      shift_q       <= shift_nx;
      bit_cnt       <= bit_cnt_nx;
      first_led     <= first_led_nx;
      blue_output   <= blue_nx;
      green_output  <= green_nx;
      red_output    <= red_nx;
      bright_output <= bright_nx;
      type_output   <= type_nx;
      led_index     <= idx_nx;
      frame_valid   <= valid_nx;
      frame_error   <= error_nx;
`ifdef DOLED_RX_TIMEOUT_EN
      idle_cnt      <= idle_nx;
`endif
    end
  end

endmodule

// File: tb/tb_doled_rx.sv
// tb_doled_rx: randomized bench for doled_rx with a frame-level reference model.
`timescale 1ns/1ps
module tb_doled_rx;
  logic       clk = 1'b0;
  logic       rst, mosi, sck;
  logic [7:0] blue_output, green_output, red_output, led_index;
  logic [4:0] bright_output;
  logic [1:0] type_output;
  logic       frame_valid, frame_error;

  always #5 clk = ~clk;

  doled_rx #(.TIMEOUT_CYCLES(1024)) dut (
    .doled_rx_clk(clk), .doled_rx_reset(rst), .mosi(mosi), .sck(sck),
    .blue_output(blue_output), .green_output(green_output), .red_output(red_output),
    .bright_output(bright_output), .type_output(type_output), .frame_valid(frame_valid),
    .led_index(led_index), .frame_error(frame_error));

  typedef struct packed {
    logic       err;
    logic [1:0] typ;
    logic [4:0] br;
    logic [7:0] b, g, r, idx;
  } ev_t;

  ev_t obs_q[$], exp_q[$];
  int  obs_cyc[$];
  int  total = 0, bad = 0, both = 0, cyc = 0, rise_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe seen on the outputs.
  always @(negedge clk) begin
    if (!rst && (frame_valid || frame_error)) begin
      if (frame_valid && frame_error) both++;
      obs_q.push_back('{frame_error, type_output, bright_output, blue_output,
                        green_output, red_output, led_index});
      obs_cyc.push_back(cyc);
    end
  end

  // Reference model: frame-level view of the bit stream.
  int          zero_run, nbits;
  bit          in_frame, first_led;
  logic [31:0] mword;
  ev_t         cur;

  task automatic model_reset();
    zero_run = 0; nbits = 0; in_frame = 0; first_led = 0; mword = 0; cur = '0;
  endtask

  task automatic model_push(bit err);
    ev_t e;
    e = cur; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic model_bit(bit b);
    zero_run = b ? 0 : (zero_run < 32 ? zero_run + 1 : 32);
    if (!in_frame) begin
      if (zero_run >= 32) begin
        in_frame = 1; nbits = 0; cur.typ = 0; cur.idx = 0; first_led = 1;
        model_push(0);
      end
    end else begin
      mword = (mword << 1) | 32'(b);
      nbits++;
      if (nbits == 32) begin
        nbits = 0;
        if (mword == 32'hFFFF_FFFF) begin
          cur.typ = 2; in_frame = 0; model_push(0);
        end else if (mword == 0) begin
          cur.typ = 0; cur.idx = 0; first_led = 1; model_push(0);
        end else if (mword[31:29] == 3'b111) begin
          cur.typ = 1; cur.br = mword[28:24]; cur.b = mword[23:16];
          cur.g = mword[15:8]; cur.r = mword[7:0];
          cur.idx = first_led ? 8'd0 : (cur.idx == 255 ? 8'd255 : cur.idx + 8'd1);
          first_led = 0;
          model_push(0);
        end else begin
          in_frame = 0; model_push(1);
        end
      end
    end
  endtask

  task automatic model_timeout();
    if (in_frame && nbits != 0) begin
      in_frame = 0; nbits = 0; model_push(1);
    end
  endtask

  // Stimulus primitives.
  task automatic do_reset();
    @(negedge clk); rst = 1; sck = 0; mosi = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    model_reset();
    obs_q.delete(); exp_q.delete(); obs_cyc.delete();
  endtask

  task automatic send_bit(bit b);
    @(negedge clk); mosi = b; sck = 0;
    @(negedge clk); @(negedge clk);
    sck = 1; rise_cyc = cyc; model_bit(b);
    @(negedge clk); @(negedge clk);
  endtask

  task automatic send_word(logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_zeros(int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  function automatic logic [31:0] rand_led();
    logic [31:0] w;
    w = {3'b111, 29'($urandom)};
    if (w == 32'hFFFF_FFFF) w[0] = 1'b0;
    return w;
  endfunction

  task automatic test_reset();
    do_reset();
    send_zeros(32); send_word(32'hFF12_3456);
    settle();
    do_reset();
    total++;
    if ({blue_output, green_output, red_output, bright_output, type_output,
         led_index, frame_valid, frame_error} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0", {blue_output, green_output,
        red_output, bright_output, type_output, led_index, frame_valid, frame_error});
    end
    send_zeros(31); settle();
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL reset_31zeros got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    send_zeros(1); settle();
    total++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      bad++; $display("FAIL reset_32zeros got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_basic();
    ev_t want;
    int  start_rise;
    do_reset();
    send_zeros(32); start_rise = rise_cyc;
    send_word(32'hE510_2030); settle();
    want = '{1'b0, 2'd1, 5'd5, 8'h10, 8'h20, 8'h30, 8'd0};
    total++;
    if (obs_q.size() != 2) begin
      bad++; $display("FAIL basic_count got=%0d exp=2", obs_q.size());
    end else begin
      total++;
      if (obs_q[0] !== exp_q[0] || obs_q[0].typ !== 2'd0) begin
        bad++; $display("FAIL basic_start got=%h exp=%h", obs_q[0], exp_q[0]);
      end
      total++;
      if (obs_q[1] !== want) begin
        bad++; $display("FAIL basic_led got=%h exp=%h", obs_q[1], want);
      end
      total++;
      if (obs_cyc[0] - start_rise != 3 || obs_cyc[1] - rise_cyc != 3) begin
        bad++; $display("FAIL basic_latency got=%0d,%0d exp=3,3",
                        obs_cyc[0] - start_rise, obs_cyc[1] - rise_cyc);
      end
    end
  endtask

  task automatic test_stream();
    do_reset();
    send_zeros(32);
    for (int i = 0; i < 47; i++) send_word(rand_led());
    send_word(32'hFFFF_FFFF);
    send_word(32'hE000_0001);   // would be an LED frame if still framing
    settle();
    total++;
    if (obs_q.size() != 49 || exp_q.size() != 49) begin
      bad++; $display("FAIL stream_count got=%0d exp=49", obs_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL stream_ev%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    total++;
    if (obs_q.size() == 49 && (obs_q[48].typ !== 2'd2 || obs_q[47].idx !== 8'd46)) begin
      bad++; $display("FAIL stream_end got=%h exp=type2 idx46", obs_q[48]);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    send_zeros(32);
    for (int i = 0; i < 258; i++) send_word(rand_led());
    settle();
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL sat_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL sat_ev%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    total++;
    if (led_index !== 8'd255) begin
      bad++; $display("FAIL sat_index got=%0d exp=255", led_index);
    end
  endtask

  task automatic test_error();
    do_reset();
    send_zeros(32); send_word(32'h4000_0000); send_zeros(32); settle();
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL err_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL err_ev%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    total++;
    if (obs_q.size() < 3 || obs_q[1].err !== 1'b1 || obs_q[2].err !== 1'b0
        || obs_q[2].typ !== 2'd0) begin
      bad++; $display("FAIL err_restart got=%0d events exp=START,ERR,START", obs_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w, c;
    do_reset();
    send_zeros(32); send_word(rand_led());
    w = rand_led();
    for (int i = 31; i >= 15; i--) send_bit(w[i]);
    do_reset();
    c = rand_led();
    send_zeros(32); send_word(c); settle();
    total++;
    if (obs_q.size() != 2 || exp_q.size() != 2) begin
      bad++; $display("FAIL midrst_count got=%0d exp=2", obs_q.size());
    end else begin
      total++;
      if (obs_q[1] !== exp_q[1] || obs_q[1] !== ev_t'({1'b0, 2'd1, c[28:0], 8'd0})) begin
        bad++; $display("FAIL midrst_led got=%h exp=%h", obs_q[1], exp_q[1]);
      end
    end
  endtask

  task automatic test_idle();
    logic [31:0] w;
    do_reset();
    w = rand_led();
    send_zeros(32);
    for (int i = 31; i >= 22; i--) send_bit(w[i]);
    repeat (1100) @(negedge clk);
`ifdef DOLED_RX_TIMEOUT_EN
    model_timeout();
`endif
    for (int i = 21; i >= 0; i--) send_bit(w[i]);
    settle();
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL idle_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL idle_ev%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int round = 0; round < 4; round++) begin
      do_reset();
      send_zeros(32);
      for (int k = 0; k < 12; k++) begin
        case ($urandom_range(0, 5))
          0:       send_zeros(32);
          1, 2:    send_word(rand_led());
          3:       send_word($urandom);
          4:       send_word(32'hFFFF_FFFF);
          default: for (int j = $urandom_range(1, 7); j > 0; j--) send_bit(1'($urandom));
        endcase
      end
      settle();
      total++;
      if (obs_q.size() != exp_q.size()) begin
        bad++; $display("FAIL rand%0d_count got=%0d exp=%0d", round, obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
        total++;
        if (obs_q[i] !== exp_q[i]) begin
          bad++; $display("FAIL rand%0d_ev%0d got=%h exp=%h", round, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_exclusive();
    total++;
    if (both != 0) begin
      bad++; $display("FAIL strobe_overlap got=%0d exp=0", both);
    end
  endtask

  initial begin
    rst = 1; sck = 0; mosi = 0;
    model_reset();
    test_reset();
    test_basic();
    test_stream();
    test_error();
    test_reset_mid();
    test_idle();
    test_random();
    test_saturate();
    test_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
